// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine coin paths.
package vend_pkg;

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

  localparam int DEN_W = 4;

  localparam logic [DEN_W-1:0] DEN_TEN  = 4'd10;
  localparam logic [DEN_W-1:0] DEN_FIVE = 4'd5;
  localparam logic [DEN_W-1:0] DEN_TWO  = 4'd2;
  localparam logic [DEN_W-1:0] DEN_ONE  = 4'd1;

  typedef struct packed {
    logic ten;
    logic five;
    logic two;
    logic one;
  } coin_sel_t;

  // Face value of a one-hot coin selection; zero when nothing is selected.
  function automatic logic [DEN_W-1:0] den_of(input coin_sel_t sel);
    logic [DEN_W-1:0] v;
    v = '0;
    if (sel.ten)       v = DEN_TEN;
    else if (sel.five) v = DEN_FIVE;
    else if (sel.two)  v = DEN_TWO;
    else if (sel.one)  v = DEN_ONE;
    return v;
  endfunction

endpackage

// File: rtl/change_phase_timer.sv
// Loadable down-counter timing the coin pulse and the gap that follows it.
module change_phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk_brd,
  input  logic             reset_brd,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_brd or negedge reset_brd) begin
    if (!reset_brd) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin-return engine: pays an amount out as timed 10/5/2/1 coin pulses,
// largest first, skipping denominations whose hopper is empty.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W     = 8,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic             clk_brd,
  input  logic             reset_brd,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             ten_empty,
  input  logic             five_empty,
  input  logic             two_empty,
  input  logic             one_empty,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             coin_ten,
  output logic             coin_five,
  output logic             coin_two,
  output logic             coin_one,
  output logic [AMT_W-1:0] remaining
);

  localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC) + 1;

  state_t           state_q, state_n;
  coin_sel_t        sel_q, sel_n, pick, coin_q;
  logic [AMT_W-1:0] rem_q, rem_n;
  logic             short_q, short_n;
  logic             busy_q, done_q;
  logic             tmr_load, tmr_expire;
  logic [TMR_W-1:0] tmr_val;

  change_phase_timer #(
    .CNT_W(TMR_W)
  ) u_timer (
    .clk_brd  (clk_brd),
    .reset_brd(reset_brd),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Largest denomination that fits the balance and is still stocked.
  always_comb begin
    pick = '0;
    if (rem_q >= AMT_W'(DEN_TEN) && !ten_empty)        pick.ten  = 1'b1;
    else if (rem_q >= AMT_W'(DEN_FIVE) && !five_empty) pick.five = 1'b1;
    else if (rem_q >= AMT_W'(DEN_TWO) && !two_empty)   pick.two  = 1'b1;
    else if (rem_q >= AMT_W'(DEN_ONE) && !one_empty)   pick.one  = 1'b1;
  end

  always_comb begin
    state_n  = state_q;
    sel_n    = sel_q;
    rem_n    = rem_q;
    short_n  = short_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_n   = amount;
          short_n = 1'b0;
          state_n = SELECT;
        end
      end
      SELECT: begin
        if (rem_q == '0) begin
          state_n = DONE;
        end else if (pick != '0) begin
          sel_n    = pick;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(PULSE_CYC - 1);
          state_n  = PULSE;
        end else begin
          short_n = 1'b1;
          state_n = DONE;
        end
      end
      PULSE: begin
        if (tmr_expire) begin
          rem_n    = rem_q - AMT_W'(den_of(sel_q));
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP_CYC - 1);
          state_n  = GAP;
        end
      end
      GAP: begin
        if (tmr_expire) state_n = SELECT;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_brd or negedge reset_brd) begin
    if (!reset_brd) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rem_q   <= '0;
      short_q <= 1'b0;
      coin_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      rem_q   <= rem_n;
      short_q <= short_n;
      coin_q  <= (state_n == PULSE) ? sel_n : '0;
      busy_q  <= (state_n != IDLE);
      done_q  <= (state_n == DONE);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign short     = short_q;
  assign remaining = rem_q;
  assign coin_ten  = coin_q.ten;
  assign coin_five = coin_q.five;
  assign coin_two  = coin_q.two;
  assign coin_one  = coin_q.one;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized scoreboard bench for change_dispenser against a greedy payout model.
module tb_change_dispenser;

  localparam int AMT_W     = 8;
  localparam int PULSE_CYC = 4;
  localparam int GAP_CYC   = 2;
  localparam int PER_COIN  = 1 + PULSE_CYC + GAP_CYC;

  logic             clk_brd = 1'b0;
  logic             reset_brd = 1'b0;
  logic             start = 1'b0;
  logic [AMT_W-1:0] amount = '0;
  logic             ten_empty = 1'b0, five_empty = 1'b0, two_empty = 1'b0, one_empty = 1'b0;
  logic             busy, done, short;
  logic             coin_ten, coin_five, coin_two, coin_one;
  logic [AMT_W-1:0] remaining;

  change_dispenser #(
    .AMT_W(AMT_W), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk_brd(clk_brd), .reset_brd(reset_brd), .start(start), .amount(amount),
    .ten_empty(ten_empty), .five_empty(five_empty), .two_empty(two_empty),
    .one_empty(one_empty), .busy(busy), .done(done), .short(short),
    .coin_ten(coin_ten), .coin_five(coin_five), .coin_two(coin_two),
    .coin_one(coin_one), .remaining(remaining)
  );

  always #5 clk_brd = ~clk_brd;

  longint cyc = 0;
  always @(posedge clk_brd) cyc <= cyc + 1;

  typedef struct { int den; int rem_before; } coin_exp_t;
  typedef struct { int rem; int shrt; int ncoins; longint done_cyc; } done_exp_t;

  coin_exp_t exp_coins[$];
  done_exp_t exp_dones[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares every coin pulse and completion against the queues.
  logic [3:0] mon_c, mon_prev = '0;
  int         mon_width = 0, mon_den = 0, mon_rem = 0, mon_coins = 0;
  bit         mon_gap = 0;
  coin_exp_t  ce;
  done_exp_t  de;

  always @(negedge clk_brd) begin
    mon_c = {coin_ten, coin_five, coin_two, coin_one};
    if (!reset_brd) begin
      mon_prev = '0; mon_width = 0; mon_gap = 0; mon_coins = 0;
    end else begin
      if (mon_gap) begin
        chk("rem_after_coin", 64'(remaining), 64'(mon_rem - mon_den));
        mon_gap = 0;
      end
      if (mon_c != '0) begin
        if ($countones(mon_c) != 1) chk("coin_onehot", 64'(mon_c), 64'(0));
        if (mon_prev == '0) begin
          mon_width = 0;
          mon_coins++;
          mon_den = mon_c[3] ? 10 : mon_c[2] ? 5 : mon_c[1] ? 2 : 1;
          if (exp_coins.size() == 0) begin
            chk("unexpected_coin", 64'(mon_den), 64'(0));
            mon_rem = int'(remaining);
          end else begin
            ce = exp_coins.pop_front();
            chk("coin_den", 64'(mon_den), 64'(ce.den));
            chk("rem_before_coin", 64'(remaining), 64'(ce.rem_before));
            mon_rem = ce.rem_before;
          end
        end else if (mon_c != mon_prev) begin
          chk("coin_switched", 64'(mon_c), 64'(mon_prev));
        end
        mon_width++;
      end else if (mon_prev != '0) begin
        chk("pulse_width", 64'(mon_width), 64'(PULSE_CYC));
        mon_gap = 1;
      end
      if (done) begin
        if (exp_dones.size() == 0) begin
          chk("unexpected_done", 64'(1), 64'(0));
        end else begin
          de = exp_dones.pop_front();
          chk("done_remaining", 64'(remaining), 64'(de.rem));
          chk("done_short", 64'(short), 64'(de.shrt));
          chk("done_cycle", 64'(cyc), 64'(de.done_cyc));
          chk("coin_count", 64'(mon_coins), 64'(de.ncoins));
          chk("busy_at_done", 64'(busy), 64'(1));
        end
        mon_coins = 0;
      end
      mon_prev = mon_c;
    end
  end

  // Greedy payout model: pushes expected coins, returns the final balance.
  task automatic model(input int amt, input logic [3:0] emp, output int rem, output int n,
                       output int sh);
    int dens[4] = '{10, 5, 2, 1};
    bit found;
    coin_exp_t c;
    rem = amt; n = 0; sh = 0;
    while (rem > 0) begin
      found = 0;
      for (int i = 0; i < 4; i++) begin
        if (!found && dens[i] <= rem && !emp[3-i]) begin
          found = 1;
          c.den = dens[i];
          c.rem_before = rem;
          exp_coins.push_back(c);
          rem -= dens[i];
          n++;
        end
      end
      if (!found) begin
        sh = 1;
        break;
      end
    end
  endtask

  task automatic run_txn(input int amt, input logic [3:0] emp, input bit inject);
    int rem, n, sh;
    done_exp_t d;
    @(posedge clk_brd); #1;
    {ten_empty, five_empty, two_empty, one_empty} = emp;
    amount = AMT_W'(amt);
    start  = 1'b1;
    model(amt, emp, rem, n, sh);
    d.rem = rem; d.shrt = sh; d.ncoins = n;
    d.done_cyc = cyc + 2 + longint'(n) * PER_COIN;
    exp_dones.push_back(d);
    @(posedge clk_brd); #1;
    start = 1'b0;
    if (inject) begin
      repeat (2) @(posedge clk_brd);
      #1; start = 1'b1; amount = AMT_W'(7);
      @(posedge clk_brd); #1; start = 1'b0;
    end
    for (int i = 0; i < 400 && exp_dones.size() != 0; i++) @(posedge clk_brd);
    if (exp_dones.size() != 0) begin
      chk("done_timeout", 64'(exp_dones.size()), 64'(0));
      exp_dones.delete();
      exp_coins.delete();
    end
    repeat (2) @(posedge clk_brd);
    #1;
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    #3;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_coins", 64'({coin_ten, coin_five, coin_two, coin_one}), 64'(0));
    chk("rst_remaining", 64'(remaining), 64'(0));
    chk("rst_short", 64'(short), 64'(0));
    repeat (3) @(posedge clk_brd);
    #1 reset_brd = 1'b1;

    run_txn(18, 4'b0000, 0);
    run_txn(0, 4'b0000, 0);
    run_txn(20, 4'b1000, 0);
    run_txn(3, 4'b0001, 0);
    run_txn(1, 4'b0000, 1);
    run_txn(255, 4'b0000, 0);

    // Asynchronous reset in the second cycle of a ten-yuan pulse.
    @(posedge clk_brd); #1;
    {ten_empty, five_empty, two_empty, one_empty} = 4'b0000;
    amount = AMT_W'(10); start = 1'b1;
    exp_coins.push_back('{den: 10, rem_before: 10});
    @(posedge clk_brd); #1 start = 1'b0;
    repeat (2) @(posedge clk_brd);
    #1;
    chk("pre_reset_coin_ten", 64'(coin_ten), 64'(1));
    #1 reset_brd = 1'b0;
    #1;
    chk("async_coin_ten", 64'(coin_ten), 64'(0));
    chk("async_busy", 64'(busy), 64'(0));
    chk("async_remaining", 64'(remaining), 64'(0));
    chk("async_short", 64'(short), 64'(0));
    repeat (2) @(posedge clk_brd);
    exp_coins.delete();
    exp_dones.delete();
    #1 reset_brd = 1'b1;
    run_txn(2, 4'b0000, 0);

    for (int k = 0; k < 40; k++) begin
      int a;
      logic [3:0] e;
      a = (k % 2 == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 255));
      e = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      run_txn(a, e, 0);
    end

    chk("leftover_coins", 64'(exp_coins.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Coin-return engine for the vending machine: the outbound counterpart of the coin-acceptance path. Given a refund/change amount in yuan, it emits one timed pulse per coin on the 10/5/2/1 coin-out lines, largest denomination first, and skips any denomination whose hopper is flagged empty. It sits between the vending controller, which issues start/amount on cancel or after a purchase, and the board coin-out drivers and display. The controller reads remaining and short when done is asserted.

Parameters:
AMT_W, 8, width of amount and remaining (yuan).
PULSE_CYC, 4, cycles each coin-out line is held high (>=1).
GAP_CYC, 2, idle cycles after each pulse before the next selection (>=1).

Ports:
clk_brd  input  1  system clock; all state on rising edge.
reset_brd  input  1  asynchronous, active-low reset.
start  input  1  request dispense; sampled only in IDLE.
amount  input  AMT_W  change to return; latched when start is accepted.
ten_empty  input  1  10-yuan hopper empty; sampled only in SELECT.
five_empty  input  1  5-yuan hopper empty; sampled only in SELECT.
two_empty  input  1  2-yuan hopper empty; sampled only in SELECT.
one_empty  input  1  1-yuan hopper empty; sampled only in SELECT.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle completion pulse.
short  output  1  valid with done: change could not be fully paid; held until the next accepted start.
coin_ten  output  1  10-yuan eject pulse.
coin_five  output  1  5-yuan eject pulse.
coin_two  output  1  2-yuan eject pulse.
coin_one  output  1  1-yuan eject pulse.
remaining  output  AMT_W  unpaid balance; held after done until the next accepted start.

Behaviour:
- Reset (asynchronous, while reset_brd=0):
  - State goes to IDLE.
  - All outputs go to 0 immediately, including coin lines mid-pulse; remaining=0, short=0.
  - A dispense in progress is abandoned; there is no resume.
- All outputs are registered.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE:
  - If start=1: latch remaining<=amount, clear short, go to SELECT.
  - start in any other state is ignored; there is no queueing.
- SELECT (exactly one cycle):
  - If remaining=0, go to DONE.
  - Otherwise choose the largest d in {10,5,2,1} with d<=remaining and the matching *_empty=0, then go to PULSE.
  - If no such d exists, go to DONE with short<=1.
- PULSE:
  - Exactly one coin line is high, for PULSE_CYC consecutive cycles.
  - On the final PULSE cycle edge: remaining<=remaining-d. The decrement is first visible in the first GAP cycle and never underflows (d<=remaining by construction).
- GAP: all coin lines low for GAP_CYC cycles, then go to SELECT.
- DONE (one cycle): done=1, then go to IDLE.
- Timing (start high in cycle 0):
  - SELECT is in cycle 1.
  - Per coin: SELECT + PULSE + GAP = 1+PULSE_CYC+GAP_CYC cycles (7 at defaults).
  - For N coins paid, done is high in cycle 2+N*(1+PULSE_CYC+GAP_CYC).
  - amount=0 gives done in cycle 2, N=0, short=0.
- Coin lines are mutually exclusive and never high outside PULSE.
- Empty flags may change between coins; each SELECT uses the current values.
- Full scale: amount=255 pays 25x10 + 1x5 (26 coins).

Decomposition:
- Shared package vend_pkg, holding:
  - state enum (IDLE, SELECT, PULSE, GAP, DONE);
  - denomination constants DEN_TEN=10, DEN_FIVE=5, DEN_TWO=2, DEN_ONE=1;
  - one-hot coin-select typedef (4 bits: ten, five, two, one).
- One sub-module, change_phase_timer: loadable down-counter (width clog2(max(PULSE_CYC,GAP_CYC))+1).
  - Load with PULSE_CYC-1 or GAP_CYC-1; raises expire on reaching 0.
  - Reused for both PULSE and GAP.
- Denomination selection stays combinational inside change_dispenser.

Test Plan:
- amount=18, no hoppers empty -> coin_ten, coin_five, coin_two, coin_one each pulse once in that order, each 4 cycles high.
  - remaining steps 18->8->3->1->0.
  - done in cycle 30; short=0.
- amount=0 -> no coin pulses; busy high for cycles 1-2; done in cycle 2; short=0; remaining=0.
- ten_empty=1, amount=20 -> four coin_five pulses, no coin_ten; done in cycle 30; short=0.
- one_empty=1, amount=3 -> one coin_two pulse.
  - At the second SELECT (cycle 8) no denomination fits, so done in cycle 9 with short=1 and remaining=1.
- start re-asserted during PULSE with amount=7, while dispensing amount=1 -> ignored.
  - Only one coin_one pulse; done in cycle 9; remaining=0.
- reset_brd driven low during the second cycle of a coin_ten pulse (amount=10) -> coin_ten drops asynchronously; busy=0, remaining=0.
  - After release, start with amount=2 dispenses one coin_two; done in cycle 9.
